// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-source writeback FIFOs, RR/age arbiter, registered RF write port, busy scoreboard; RF_WB_BYPASS_EN adds forwarding lookups.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_data,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy,
  output logic                         idle
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]        fwd_raddr1,
  input  logic [ADDR_WIDTH-1:0]        fwd_raddr2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_WIDTH-1:0]        fwd_data1,
  output logic [DATA_WIDTH-1:0]        fwd_data2
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2*FIFO_DEPTH) + 1;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [TW-1:0] tag_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0] cnt_t;
  addr_t q_addr [2][FIFO_DEPTH];
  data_t q_data [2][FIFO_DEPTH];
  tag_t  q_tag  [2][FIFO_DEPTH];
  logic  occ    [2][FIFO_DEPTH];
  ptr_t  rd_ptr [2];
  ptr_t  wr_ptr [2];
  cnt_t  cnt    [2];
  addr_t in_addr [2];
  addr_t head_addr [2];
  data_t in_data [2];
  data_t head_data [2];
  tag_t  in_tag [2];
  tag_t  head_tag [2];
  logic [1:0] in_valid, push, enq, ne, gnt;
  tag_t seq, age;
  logic rr, same;
  assign in_valid = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;
  assign a_ready = !rst && cnt[0] != cnt_t'(FIFO_DEPTH);
  assign b_ready = !rst && cnt[1] != cnt_t'(FIFO_DEPTH);
  assign push = in_valid & {b_ready, a_ready};
  // Address-0 pushes complete the handshake but never occupy a slot or a tag.
  assign enq[0] = push[0] && in_addr[0] != '0;
  assign enq[1] = push[1] && in_addr[1] != '0;
  assign ne[0] = cnt[0] != '0;
  assign ne[1] = cnt[1] != '0;
  assign in_tag[0] = seq;
  assign in_tag[1] = seq + tag_t'(enq[0]);
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      head_addr[s] = q_addr[s][rd_ptr[s]];
      head_data[s] = q_data[s][rd_ptr[s]];
      head_tag[s]  = q_tag[s][rd_ptr[s]];
      for (int i = 0; i < FIFO_DEPTH; i++)
        occ[s][i] = {1'b0, ptr_t'(ptr_t'(i) - rd_ptr[s])} < cnt[s];
    end
  end
  // Tags are never more than 2*FIFO_DEPTH apart, so the sign of the modular difference gives age.
  assign same = head_addr[0] == head_addr[1];
  assign age = head_tag[0] - head_tag[1];
  assign gnt[0] = ne[0] && (!ne[1] || (same ? age[TW-1] : !rr));
  assign gnt[1] = ne[1] && !gnt[0];
  always_ff @(posedge clk)
    for (int s = 0; s < 2; s++)
      if (enq[s]) begin
        q_addr[s][wr_ptr[s]] <= in_addr[s];
        q_data[s][wr_ptr[s]] <= in_data[s];
        q_tag[s][wr_ptr[s]]  <= in_tag[s];
      end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s] <= '0;
      end
      rr <= 1'b0;
      seq <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= wr_ptr[s] + ptr_t'(enq[s]);
        rd_ptr[s] <= rd_ptr[s] + ptr_t'(gnt[s]);
        cnt[s] <= cnt[s] + cnt_t'(enq[s]) - cnt_t'(gnt[s]);
      end
      // Age-decided grants leave the pointer alone; otherwise it points away from the winner.
      if (gnt != 2'b00 && !(ne == 2'b11 && same)) rr <= gnt[0];
      seq <= seq + tag_t'(enq[0]) + tag_t'(enq[1]);
      rf_wen <= |gnt;
      if (|gnt) begin
        rf_waddr <= gnt[0] ? head_addr[0] : head_addr[1];
        rf_wdata <= gnt[0] ? head_data[0] : head_data[1];
      end
    end
  always_comb begin
    busy = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (occ[s][i]) busy[q_addr[s][i]] = 1'b1;
    if (rf_wen) busy[rf_waddr] = 1'b1;
    busy[0] = 1'b0;
  end
  assign idle = ne == 2'b00 && !rf_wen;
`ifdef RF_WB_BYPASS_EN
  for (genvar k = 0; k < 2; k++) begin : g_fwd
    addr_t raddr;
    data_t data;
    tag_t best, dt;
    logic hit, fifo_hit;
    assign raddr = k == 0 ? fwd_raddr1 : fwd_raddr2;
    // Output stage is the oldest candidate; any younger FIFO match overrides it.
    always_comb begin
      hit = rf_wen && rf_waddr == raddr;
      data = rf_wdata;
      best = '0;
      dt = '0;
      fifo_hit = 1'b0;
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          dt = q_tag[s][i] - best;
          if (occ[s][i] && q_addr[s][i] == raddr && (!fifo_hit || !dt[TW-1])) begin
            fifo_hit = 1'b1;
            best = q_tag[s][i];
            hit = 1'b1;
            data = q_data[s][i];
          end
        end
      if (raddr == '0 || !hit) begin
        hit = 1'b0;
        data = '0;
      end
    end
  end
  assign fwd_hit1 = g_fwd[0].hit;
  assign fwd_hit2 = g_fwd[1].hit;
  assign fwd_data1 = g_fwd[0].data;
  assign fwd_data2 = g_fwd[1].data;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of reset, latency, arbitration order, backpressure, address-0 drop and optional bypass.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready, rf_wen, idle;
  logic [AW-1:0] a_addr = '0, b_addr = '0, rf_waddr;
  logic [DW-1:0] a_data = '0, b_data = '0, rf_wdata;
  logic [(1<<AW)-1:0] busy;
  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] log_q [$];
  logic [AW+DW-1:0] exp_e;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] fwd_raddr1 = '0, fwd_raddr2 = '0;
  logic fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
`endif

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .idle(idle)
`ifdef RF_WB_BYPASS_EN
    , .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rf_wen) log_q.push_back({rf_waddr, rf_wdata});

  task automatic do_reset;
    @(negedge clk);
    a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    #2 rst = 1;
    #4 rst = 0;
    @(negedge clk);
    log_q.delete();
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
    checks++; if (busy !== '0 || idle !== 1'b1) begin errors++; $display("FAIL reset_busy_idle: got busy=%h idle=%b want 0 1", busy, idle); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got a=%b b=%b want 1 1", a_ready, b_ready); end
    checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_port: got %h %h want 0 0", rf_waddr, rf_wdata); end
    a_valid = 1; a_addr = 4; a_data = 32'h44;
    @(negedge clk); a_valid = 0;
    checks++; if (busy[4] !== 1'b1) begin errors++; $display("FAIL pre_flush_busy4: got %b want 1", busy[4]); end
    #2 rst = 1;
    #1;
    checks++; if (busy !== '0 || idle !== 1'b1 || rf_wen !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL midop_reset: got busy=%h idle=%b wen=%b a_ready=%b want 0 1 0 0", busy, idle, rf_wen, a_ready); end
    @(negedge clk); rst = 0; log_q.delete();
    repeat (3) @(negedge clk);
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL flushed_write: got %0d writes want 0", log_q.size()); end
  endtask

  task automatic test_single_a;
    do_reset();
    a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF;
    @(negedge clk); a_valid = 0;
    checks++; if (busy[3] !== 1'b1 || rf_wen !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL single_n1: got busy3=%b wen=%b idle=%b want 1 0 0", busy[3], rf_wen, idle); end
    @(negedge clk);
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_n2: got wen=%b addr=%0d data=%h want 1 3 deadbeef", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL single_busy_n2: got %b want 1", busy[3]); end
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0 || busy[3] !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL single_n3: got wen=%b busy3=%b idle=%b want 0 0 1", rf_wen, busy[3], idle); end
    checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got %0d %h want 3 deadbeef", rf_waddr, rf_wdata); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    a_valid = 1; a_addr = 5; a_data = 32'h11;
    b_valid = 1; b_addr = 6; b_data = 32'h22;
    @(negedge clk); a_valid = 0; b_valid = 0;
    checks++; if (busy[6:5] !== 2'b11) begin errors++; $display("FAIL simul_busy: got %b want 11", busy[6:5]); end
    @(negedge clk);
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin errors++; $display("FAIL simul_first: got wen=%b addr=%0d data=%h want 1 5 11", rf_wen, rf_waddr, rf_wdata); end
    @(negedge clk);
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h22) begin errors++; $display("FAIL simul_second: got wen=%b addr=%0d data=%h want 1 6 22", rf_wen, rf_waddr, rf_wdata); end
    a_valid = 1; a_addr = 10; a_data = 32'h33;
    b_valid = 1; b_addr = 11; b_data = 32'h44;
    @(negedge clk); a_valid = 0; b_valid = 0;
    @(negedge clk);
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h33) begin errors++; $display("FAIL rr_back_to_a: got wen=%b addr=%0d data=%h want 1 10 33", rf_wen, rf_waddr, rf_wdata); end
    @(negedge clk);
    checks++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'h44) begin errors++; $display("FAIL rr_then_b: got addr=%0d data=%h want 11 44", rf_waddr, rf_wdata); end
  endtask

  task automatic test_same_addr;
    logic [AW+DW-1:0] exp_t [4];
    do_reset();
    b_valid = 1; b_addr = 7; b_data = 32'hBB;
    @(negedge clk); b_valid = 0;
    a_valid = 1; a_addr = 7; a_data = 32'hAA;
    @(negedge clk); a_valid = 0;
    repeat (4) @(negedge clk);
    checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL same_addr_count: got %0d want 2", log_q.size()); end
    else begin
      checks++; if (log_q[0] !== {5'd7, 32'hBB} || log_q[1] !== {5'd7, 32'hAA}) begin errors++; $display("FAIL same_addr_order: got %h %h want 07000000bb 07000000aa", log_q[0], log_q[1]); end
    end
    do_reset();
    a_valid = 1; a_addr = 24; a_data = 32'hA0;
    b_valid = 1; b_addr = 30; b_data = 32'hB0;
    @(negedge clk); a_valid = 0;
    b_addr = 21; b_data = 32'hB1;
    @(negedge clk); b_valid = 0;
    a_valid = 1; a_addr = 21; a_data = 32'hA2;
    @(negedge clk); a_valid = 0;
    checks++; if (busy[21] !== 1'b1) begin errors++; $display("FAIL tag_busy21: got %b want 1", busy[21]); end
    repeat (4) @(negedge clk);
    exp_t[0] = {5'd24, 32'hA0}; exp_t[1] = {5'd30, 32'hB0};
    exp_t[2] = {5'd21, 32'hB1}; exp_t[3] = {5'd21, 32'hA2};
    checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL tag_count: got %0d want 4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[i] !== exp_t[i]) begin errors++; $display("FAIL tag_order[%0d]: got %h want %h", i, log_q[i], exp_t[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int na, nb;
    na = 0; nb = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      a_valid = na < 4; a_addr = AW'(1 + na); a_data = 32'hA0 + 32'(na);
      b_valid = nb < 4; b_addr = AW'(16 + nb); b_data = 32'hB0 + 32'(nb);
      if (c == 2) begin
        checks++; if (b_ready !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL bp_b_full: got a=%b b=%b want 1 0", a_ready, b_ready); end
      end
      if (c == 3) begin
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_full: got %b want 0", a_ready); end
      end
      na += int'(a_valid && a_ready);
      nb += int'(b_valid && b_ready);
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
    checks++; if (na != 4 || nb != 4) begin errors++; $display("FAIL bp_accepted: got a=%0d b=%0d want 4 4", na, nb); end
    checks++; if (log_q.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", log_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      exp_e = (i % 2 == 0) ? {AW'(1 + i/2), 32'hA0 + 32'(i/2)} : {AW'(16 + i/2), 32'hB0 + 32'(i/2)};
      checks++; if (log_q[i] !== exp_e) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, log_q[i], exp_e); end
    end
  endtask

  task automatic test_addr0;
    do_reset();
    a_valid = 1; a_addr = 0; a_data = 32'h55;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL addr0_ready: got %b want 1", a_ready); end
    @(negedge clk); a_valid = 0;
    checks++; if (busy !== '0 || idle !== 1'b1) begin errors++; $display("FAIL addr0_state: got busy=%h idle=%b want 0 1", busy, idle); end
    repeat (3) @(negedge clk);
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL addr0_write: got %0d writes want 0", log_q.size()); end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass;
    do_reset();
    fwd_raddr1 = 9; fwd_raddr2 = 0;
    a_valid = 1; a_addr = 9; a_data = 32'h1;
    @(negedge clk); a_data = 32'h2;
    @(negedge clk); a_valid = 0;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h2) begin errors++; $display("FAIL fwd1_youngest: got hit=%b data=%h want 1 2", fwd_hit1, fwd_data1); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== '0) begin errors++; $display("FAIL fwd2_addr0: got hit=%b data=%h want 0 0", fwd_hit2, fwd_data2); end
    fwd_raddr2 = 8; #1;
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== '0) begin errors++; $display("FAIL fwd2_miss: got hit=%b data=%h want 0 0", fwd_hit2, fwd_data2); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_simultaneous();
    test_same_addr();
    test_back_to_back();
    test_addr0();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
